// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read path: responder FSM states and the
// default widths used by sdram_read_intf and sdram_read_responder.
package sdram_pkg;

    localparam int DEF_ADDR_W = 25;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } sdram_rd_state_t;

endpackage

// File: rtl/sdram_read_intf.sv
// Requester/responder read channel: one request (addr, count, start) in,
// a stream of data beats and a single done pulse back.
interface sdram_read_intf #(
    parameter int ADDR_W = sdram_pkg::DEF_ADDR_W,
    parameter int DATA_W = sdram_pkg::DEF_DATA_W,
    parameter int CNT_W  = sdram_pkg::DEF_CNT_W
);
    logic [ADDR_W-1:0] read_addr;
    logic [CNT_W-1:0]  read_cnt;
    logic              read_start;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              read_done;

    modport responder (
        input  read_addr, read_cnt, read_start,
        output read_data, read_valid, read_done
    );

    modport requester (
        output read_addr, read_cnt, read_start,
        input  read_data, read_valid, read_done
    );
endinterface

// File: rtl/sdram_read_responder.sv
// Splits one requester read into Avalon-MM bursts of at most MAX_BURST words
// and forwards each returned word as a read_valid beat, ending with read_done.
module sdram_read_responder
    import sdram_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_BURST = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    sdram_read_intf.responder            req,
    output logic                         busy,
    output logic [ADDR_W-1:0]            avm_address,
    output logic [$clog2(MAX_BURST):0]   avm_burstcount,
    output logic                         avm_read,
    input  logic                         avm_waitrequest,
    input  logic [DATA_W-1:0]            avm_readdata,
    input  logic                         avm_readdatavalid
);

    localparam int BC_W = $clog2(MAX_BURST) + 1;

    sdram_rd_state_t   state;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  remaining;
    logic [BC_W-1:0]   beat_cnt;
    logic [BC_W-1:0]   blen;
    logic [BC_W-1:0]   start_blen;

    function automatic logic [BC_W-1:0] blen_of(input logic [CNT_W-1:0] words);
        if (words >= CNT_W'(MAX_BURST))
            return BC_W'(MAX_BURST);
        return BC_W'(words);
    endfunction

    assign blen       = blen_of(remaining);
    assign start_blen = blen_of(req.read_cnt);

    // NOTE: all state and outputs use non-blocking assignments so every branch
    // below sees the values from the start of the cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cur_addr       <= '0;
            remaining      <= '0;
            beat_cnt       <= '0;
            busy           <= 1'b0;
            avm_read       <= 1'b0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            req.read_data  <= '0;
            req.read_valid <= 1'b0;
            req.read_done  <= 1'b0;
        end else begin
            req.read_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req.read_start) begin
                        cur_addr  <= req.read_addr;
                        remaining <= req.read_cnt;
                        busy      <= 1'b1;
                        if (req.read_cnt == '0) begin
                            req.read_done <= 1'b1;
                            state         <= DONE;
                        end else begin
                            avm_read       <= 1'b1;
                            avm_address    <= req.read_addr;
                            avm_burstcount <= start_blen;
                            state          <= CMD;
                        end
                    end
                end
                CMD: begin
                    if (!avm_waitrequest) begin
                        avm_read  <= 1'b0;
                        cur_addr  <= cur_addr + ADDR_W'(blen);
                        remaining <= remaining - CNT_W'(blen);
                        beat_cnt  <= blen;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    // Burst drained with nothing left: done follows the last beat by one cycle.
                    if (beat_cnt == '0) begin
                        req.read_done <= 1'b1;
                        state         <= DONE;
                    end else if (avm_readdatavalid) begin
                        req.read_valid <= 1'b1;
                        req.read_data  <= avm_readdata;
                        beat_cnt       <= beat_cnt - BC_W'(1);
                        if (beat_cnt == BC_W'(1) && remaining != '0) begin
                            avm_read       <= 1'b1;
                            avm_address    <= cur_addr;
                            avm_burstcount <= blen;
                            state          <= CMD;
                        end
                    end
                end
                DONE: begin
                    req.read_done <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
